l1_dcache_ctrl: RTL and testbench

L1_DCACHE_CTRL -- requirements
Module: l1_dcache_ctrl

---
 rtl/l1_dcache_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_l1_dcache_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache_ctrl.sv
// l1_dcache_ctrl
//   Direct-mapped, write-through L1 data cache controller with a single-word
//   memory interface. Read hits complete with zero stall and registered rdata.
//   Misses refill a whole line word by word. Writes always go through to
//   memory, optionally allocating on a miss. Addresses outside
//   [CACHE_START, CACHE_END] bypass the cache with a single-word access.
//
// Ports
//   clk, rst          : single clock, asynchronous active-high reset
//   cs, we, addr,
//   wdata             : CPU request (word-aligned byte address)
//   rdata             : registered read data
//   stall             : CPU request not yet consumed (combinational)
//   flush             : one-cycle invalidate-all pulse
//   mem_req, mem_we,
//   mem_addr,
//   mem_wdata         : registered memory request, held until mem_ack
//   mem_ack,
//   mem_rdata         : memory word completion and read data

module l1_dcache_ctrl #(
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           CACHE_SIZE     = 4096,
   parameter int unsigned           BLOCK_SIZE     = 32,
   parameter logic [ADDR_WIDTH-1:0] CACHE_START    = 32'h40000000,
   parameter logic [ADDR_WIDTH-1:0] CACHE_END      = 32'h400FFFFF,
   parameter int unsigned           WRITE_ALLOCATE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  stall,
   input  logic                  flush,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata
);

   localparam int unsigned WORDS = BLOCK_SIZE / 4;
   localparam int unsigned LINES = CACHE_SIZE / BLOCK_SIZE;
   localparam int unsigned OFF_W = $clog2(BLOCK_SIZE);
   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned WRD_W = OFF_W - 2;
   localparam int unsigned TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int unsigned SEL_W = IDX_W + WRD_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    req_we_q, req_we_d;
   logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
   logic [31:0]             req_wdata_q, req_wdata_d;
   logic                    req_unc_q, req_unc_d;
   logic [WRD_W-1:0]        word_q, word_d;
   logic                    flush_pend_q, flush_pend_d;
   logic [LINES-1:0]        valid_q, valid_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    mem_req_q, mem_req_d;
   logic                    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]             mem_wdata_q, mem_wdata_d;

   // Storage arrays carry no reset; a line is only trusted through valid_q.
   logic [TAG_W-1:0]        tag_q  [LINES];
   logic [31:0]             data_q [LINES*WORDS];

   logic                    tag_we_s;
   logic                    data_we_s;
   logic [SEL_W-1:0]        data_wsel_s;
   logic [31:0]             data_wval_s;

   logic [IDX_W-1:0]        in_idx_s;
   logic [TAG_W-1:0]        in_tag_s;
   logic [WRD_W-1:0]        in_wrd_s;
   logic                    cacheable_s;
   logic                    hit_s;
   logic                    read_hit_s;
   logic [IDX_W-1:0]        req_idx_s;
   logic [TAG_W-1:0]        req_tag_s;
   logic [WRD_W-1:0]        req_wrd_s;
   logic                    last_word_s;
   logic [WRD_W-1:0]        word_inc_s;
   logic                    stall_s;

   // Address decode of the incoming request and of the held request.
   always_comb begin
      in_idx_s    = addr[OFF_W +: IDX_W];
      in_tag_s    = addr[ADDR_WIDTH-1 -: TAG_W];
      in_wrd_s    = addr[2 +: WRD_W];
      cacheable_s = (addr >= CACHE_START) && (addr <= CACHE_END);
      hit_s       = cacheable_s && valid_q[in_idx_s] && (tag_q[in_idx_s] == in_tag_s);
      read_hit_s  = cs && !we && hit_s;
      req_idx_s   = req_addr_q[OFF_W +: IDX_W];
      req_tag_s   = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
      req_wrd_s   = req_addr_q[2 +: WRD_W];
      last_word_s = (word_q == WRD_W'(WORDS - 1));
      word_inc_s  = word_q + WRD_W'(1);
   end

   // Stall: only a read hit in IDLE and the DONE cycle release the CPU.
   always_comb begin
      stall_s = 1'b0;
      case (state_q)
         IDLE:    stall_s = cs && !read_hit_s;
         REFILL:  stall_s = 1'b1;
         WRITE:   stall_s = 1'b1;
         DONE:    stall_s = 1'b0;
         default: stall_s = 1'b0;
      endcase
   end

   // Next-state, memory request, array write strobes and read data.
   always_comb begin
      state_d      = state_q;
      req_we_d     = req_we_q;
      req_addr_d   = req_addr_q;
      req_wdata_d  = req_wdata_q;
      req_unc_d    = req_unc_q;
      word_d       = word_q;
      flush_pend_d = flush_pend_q;
      valid_d      = valid_q;
      rdata_d      = rdata_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      tag_we_s     = 1'b0;
      data_we_s    = 1'b0;
      data_wsel_s  = {SEL_W{1'b0}};
      data_wval_s  = 32'h0;

      case (state_q)
         IDLE: begin
            // Lookup below reads valid_q, so a coincident read hit sees pre-flush state.
            if (flush || flush_pend_q) begin
               valid_d      = {LINES{1'b0}};
               flush_pend_d = 1'b0;
            end else begin
               valid_d      = valid_q;
            end
            if (cs) begin
               req_we_d    = we;
               req_addr_d  = addr;
               req_wdata_d = wdata;
               req_unc_d   = !cacheable_s;
               if (read_hit_s) begin
                  rdata_d = data_q[{in_idx_s, in_wrd_s}];
               end else if (!cacheable_s) begin
                  state_d     = we ? WRITE : REFILL;
                  word_d      = {WRD_W{1'b0}};
                  mem_req_d   = 1'b1;
                  mem_we_d    = we;
                  mem_addr_d  = addr;
                  mem_wdata_d = wdata;
               end else if (!we || ((WRITE_ALLOCATE != 0) && !hit_s)) begin
                  // Line refill: read miss, or allocating write miss.
                  state_d     = REFILL;
                  word_d      = {WRD_W{1'b0}};
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = {addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                  mem_wdata_d = 32'h0;
               end else begin
                  // Write hit updates the line now; non-allocating miss only writes memory.
                  if (hit_s) begin
                     data_we_s   = 1'b1;
                     data_wsel_s = {in_idx_s, in_wrd_s};
                     data_wval_s = wdata;
                  end else begin
                     data_we_s   = 1'b0;
                  end
                  state_d     = WRITE;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = addr;
                  mem_wdata_d = wdata;
               end
            end else begin
               state_d = IDLE;
            end
         end

         REFILL: begin
            if (flush) begin
               flush_pend_d = 1'b1;
            end else begin
               flush_pend_d = flush_pend_q;
            end
            if (mem_ack) begin
               if (req_unc_q) begin
                  rdata_d   = mem_rdata;
                  mem_req_d = 1'b0;
                  state_d   = DONE;
               end else begin
                  // A pending write's data replaces the fetched word it targets.
                  data_we_s   = 1'b1;
                  data_wsel_s = {req_idx_s, word_q};
                  data_wval_s = (req_we_q && (word_q == req_wrd_s)) ? req_wdata_q : mem_rdata;
                  if (last_word_s) begin
                     valid_d[req_idx_s] = 1'b1;
                     tag_we_s           = 1'b1;
                     if (req_we_q) begin
                        state_d     = WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = req_addr_q;
                        mem_wdata_d = req_wdata_q;
                     end else begin
                        state_d   = DONE;
                        mem_req_d = 1'b0;
                        // The requested word is either arriving now or already stored.
                        rdata_d   = (word_q == req_wrd_s) ? mem_rdata
                                                          : data_q[{req_idx_s, req_wrd_s}];
                     end
                  end else begin
                     word_d     = word_inc_s;
                     mem_addr_d = {req_addr_q[ADDR_WIDTH-1:OFF_W], word_inc_s, 2'b00};
                  end
               end
            end else begin
               state_d = REFILL;
            end
         end

         WRITE: begin
            if (flush) begin
               flush_pend_d = 1'b1;
            end else begin
               flush_pend_d = flush_pend_q;
            end
            if (mem_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = DONE;
            end else begin
               state_d = WRITE;
            end
         end

         DONE: begin
            // Apply any latched flush here so IDLE already sees an empty cache.
            if (flush || flush_pend_q) begin
               valid_d      = {LINES{1'b0}};
               flush_pend_d = 1'b0;
            end else begin
               valid_d      = valid_q;
            end
            state_d = IDLE;
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   // Control and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         req_we_q     <= 1'b0;
         req_addr_q   <= {ADDR_WIDTH{1'b0}};
         req_wdata_q  <= 32'h0;
         req_unc_q    <= 1'b0;
         word_q       <= {WRD_W{1'b0}};
         flush_pend_q <= 1'b0;
         valid_q      <= {LINES{1'b0}};
         rdata_q      <= 32'h0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= {ADDR_WIDTH{1'b0}};
         mem_wdata_q  <= 32'h0;
      end else begin
         state_q      <= state_d;
         req_we_q     <= req_we_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_unc_q    <= req_unc_d;
         word_q       <= word_d;
         flush_pend_q <= flush_pend_d;
         valid_q      <= valid_d;
         rdata_q      <= rdata_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Tag and data array writes.
   always_ff @(posedge clk) begin
      if (tag_we_s) begin
         tag_q[req_idx_s] <= req_tag_s;
      end
      if (data_we_s) begin
         data_q[data_wsel_s] <= data_wval_s;
      end
   end

   assign rdata     = rdata_q;
   assign stall     = stall_s;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl: instance 0 allocates on write miss,
// instance 1 does not. Each instance has a 1-cycle-ack memory model whose
// read data is a fixed function of address (writes are not stored).

module tb_l1_dcache_ctrl;

   localparam int WORDS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs_v [2];
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        flush;
   logic [31:0] rdata_v [2];
   logic        stall_v [2];
   logic        mem_req_v [2];
   logic        mem_we_v [2];
   logic [31:0] mem_addr_v [2];
   logic [31:0] mem_wdata_v [2];
   logic        mem_ack_v [2] = '{1'b0, 1'b0};
   logic [31:0] mem_rdata_v [2] = '{32'h0, 32'h0};

   int          rd_cnt [2] = '{0, 0};
   int          wr_cnt [2] = '{0, 0};
   logic [31:0] rd_log [2][16];
   logic [31:0] last_waddr [2];
   logic [31:0] last_wdata [2];

   int          n_chk  = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   l1_dcache_ctrl #(.WRITE_ALLOCATE(1)) dut_wa (
      .clk(clk), .rst(rst), .cs(cs_v[0]), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata_v[0]), .stall(stall_v[0]), .flush(flush),
      .mem_req(mem_req_v[0]), .mem_we(mem_we_v[0]), .mem_addr(mem_addr_v[0]),
      .mem_wdata(mem_wdata_v[0]), .mem_ack(mem_ack_v[0]), .mem_rdata(mem_rdata_v[0])
   );

   l1_dcache_ctrl #(.WRITE_ALLOCATE(0)) dut_na (
      .clk(clk), .rst(rst), .cs(cs_v[1]), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata_v[1]), .stall(stall_v[1]), .flush(1'b0),
      .mem_req(mem_req_v[1]), .mem_we(mem_we_v[1]), .mem_addr(mem_addr_v[1]),
      .mem_wdata(mem_wdata_v[1]), .mem_ack(mem_ack_v[1]), .mem_rdata(mem_rdata_v[1])
   );

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a[31:28] == 4'h4) mem_val = 32'hA0 + {29'd0, a[4:2]};
      else                  mem_val = 32'hC0DE0000 | {16'd0, a[15:0]};
   endfunction

   // Memory models (unaware of rst) and transfer monitor.
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (mem_req_v[g] && mem_ack_v[g]) begin
            if (mem_we_v[g]) begin
               wr_cnt[g]     <= wr_cnt[g] + 1;
               last_waddr[g] <= mem_addr_v[g];
               last_wdata[g] <= mem_wdata_v[g];
            end else begin
               rd_log[g][rd_cnt[g] % 16] <= mem_addr_v[g];
               rd_cnt[g]                 <= rd_cnt[g] + 1;
            end
         end
         mem_ack_v[g]   <= mem_req_v[g] && !mem_ack_v[g];
         mem_rdata_v[g] <= mem_val(mem_addr_v[g]);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a negedge with the request driven; returns after the consuming edge.
   task automatic wait_consume(input int inst, input string name, output int stalls);
      bit done;
      done   = 1'b0;
      stalls = 0;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (!stall_v[inst]) begin
            done = 1'b1;
            break;
         end
         stalls++;
         @(negedge clk);
      end
      if (done) begin
         @(posedge clk);
         #1;
      end else begin
         check({name, " timeout"}, 32'd1, 32'd0);
      end
      cs_v[inst] = 1'b0;
   endtask

   task automatic post_checks(input int inst, input string name, input logic [31:0] a,
                              input logic [31:0] d, input logic chk_rd, input logic [31:0] exp_rd,
                              input int rds, input int wrs, input int rb, input int wb,
                              input int stalls);
      logic [31:0] base;
      base = {a[31:5], 5'd0};
      if (chk_rd) check({name, " rdata"}, rdata_v[inst], exp_rd);
      check({name, " reads"}, 32'(rd_cnt[inst] - rb), 32'(rds));
      check({name, " writes"}, 32'(wr_cnt[inst] - wb), 32'(wrs));
      if (rds == 0 && wrs == 0) begin
         check({name, " hit stalls"}, 32'(stalls), 32'd0);
         check({name, " hit mem_req"}, {31'd0, mem_req_v[inst]}, 32'd0);
      end
      if (rds == WORDS) begin
         for (int n = 0; n < WORDS; n++)
            check($sformatf("%s raddr%0d", name, n), rd_log[inst][(rb + n) % 16], base + 32'(4 * n));
      end else if (rds == 1) begin
         check({name, " raddr"}, rd_log[inst][rb % 16], a);
      end
      if (wrs == 1) begin
         check({name, " waddr"}, last_waddr[inst], a);
         check({name, " wdata"}, last_wdata[inst], d);
      end
   endtask

   task automatic do_txn(input int inst, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic chk_rd, input logic [31:0] exp_rd, input int rds,
                         input int wrs, input string name);
      int rb, wb, stalls;
      @(negedge clk);
      rb    = rd_cnt[inst];
      wb    = wr_cnt[inst];
      we    = w;
      addr  = a;
      wdata = d;
      cs_v[inst] = 1'b1;
      wait_consume(inst, name, stalls);
      post_checks(inst, name, a, d, chk_rd, exp_rd, rds, wrs, rb, wb, stalls);
   endtask

   typedef struct {
      int          inst;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic        chk;
      logic [31:0] exp;
      int          rds;
      int          wrs;
   } vec_t;

   vec_t vecs [$];

   initial begin
      int rb, wb, stalls;
      bit got;

      vecs.push_back('{0, 1'b0, 32'h40000010, 32'h0,        1'b1, 32'h000000A4, 8, 0});
      vecs.push_back('{0, 1'b0, 32'h40000010, 32'h0,        1'b1, 32'h000000A4, 0, 0});
      vecs.push_back('{0, 1'b1, 32'h40000010, 32'h12345678, 1'b0, 32'h0,        0, 1});
      vecs.push_back('{0, 1'b0, 32'h40000010, 32'h0,        1'b1, 32'h12345678, 0, 0});
      vecs.push_back('{0, 1'b0, 32'h4000001C, 32'h0,        1'b1, 32'h000000A7, 0, 0});
      vecs.push_back('{0, 1'b1, 32'h40000404, 32'hDEADBEEF, 1'b0, 32'h0,        8, 1});
      vecs.push_back('{0, 1'b0, 32'h40000404, 32'h0,        1'b1, 32'hDEADBEEF, 0, 0});
      vecs.push_back('{0, 1'b0, 32'h40000408, 32'h0,        1'b1, 32'h000000A2, 0, 0});
      vecs.push_back('{0, 1'b0, 32'h00000100, 32'h0,        1'b1, 32'hC0DE0100, 1, 0});
      vecs.push_back('{0, 1'b0, 32'h00000100, 32'h0,        1'b1, 32'hC0DE0100, 1, 0});
      vecs.push_back('{0, 1'b1, 32'h00000104, 32'h00000055, 1'b0, 32'h0,        0, 1});
      vecs.push_back('{0, 1'b0, 32'h400FFFFC, 32'h0,        1'b1, 32'h000000A7, 8, 0});
      vecs.push_back('{0, 1'b0, 32'h400FFFFC, 32'h0,        1'b1, 32'h000000A7, 0, 0});
      vecs.push_back('{0, 1'b0, 32'h40100000, 32'h0,        1'b1, 32'h000000A0, 1, 0});
      vecs.push_back('{0, 1'b0, 32'h40100000, 32'h0,        1'b1, 32'h000000A0, 1, 0});
      vecs.push_back('{0, 1'b0, 32'h3FFFFFFC, 32'h0,        1'b1, 32'hC0DEFFFC, 1, 0});
      vecs.push_back('{1, 1'b1, 32'h40000400, 32'h11111111, 1'b0, 32'h0,        0, 1});
      vecs.push_back('{1, 1'b0, 32'h40000400, 32'h0,        1'b1, 32'h000000A0, 8, 0});
      vecs.push_back('{1, 1'b0, 32'h40000400, 32'h0,        1'b1, 32'h000000A0, 0, 0});
      vecs.push_back('{1, 1'b1, 32'h40000400, 32'h00000022, 1'b0, 32'h0,        0, 1});
      vecs.push_back('{1, 1'b0, 32'h40000400, 32'h0,        1'b1, 32'h00000022, 0, 0});

      rst = 1'b1; cs_v[0] = 1'b0; cs_v[1] = 1'b0; we = 1'b0;
      addr = 32'h0; wdata = 32'h0; flush = 1'b0;
      repeat (2) @(negedge clk);
      check("reset rdata",     rdata_v[0], 32'h0);
      check("reset mem_req",   {31'd0, mem_req_v[0]}, 32'd0);
      check("reset mem_addr",  mem_addr_v[0], 32'h0);
      check("reset stall",     {31'd0, stall_v[0]}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         do_txn(vecs[i].inst, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].chk, vecs[i].exp,
                vecs[i].rds, vecs[i].wrs, $sformatf("vec%0d", i));

      // Read hit coinciding with flush returns pre-flush data, then the line is gone.
      @(negedge clk);
      we = 1'b0; addr = 32'h40000010; cs_v[0] = 1'b1; flush = 1'b1;
      #1;
      check("flush-hit stall", {31'd0, stall_v[0]}, 32'd0);
      @(posedge clk);
      #1;
      cs_v[0] = 1'b0; flush = 1'b0;
      check("flush-hit rdata", rdata_v[0], 32'h12345678);
      do_txn(0, 1'b0, 32'h40000010, 32'h0, 1'b1, 32'h000000A4, 8, 0, "post-flush read");

      // Flush pulsed in the middle of a refill.
      @(negedge clk);
      rb = rd_cnt[0]; wb = wr_cnt[0];
      we = 1'b0; addr = 32'h40000800; cs_v[0] = 1'b1;
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      wait_consume(0, "flush-refill", stalls);
      post_checks(0, "flush-refill", 32'h40000800, 32'h0, 1'b1, 32'h000000A0, 8, 0, rb, wb, stalls);
      do_txn(0, 1'b0, 32'h40000010, 32'h0, 1'b1, 32'h000000A4, 8, 0, "flushed line0");
      do_txn(0, 1'b0, 32'h40000800, 32'h0, 1'b1, 32'h000000A0, 8, 0, "flushed line64");

      // Reset after three refill acks.
      @(negedge clk);
      rb = rd_cnt[0];
      we = 1'b0; addr = 32'h40000C00; cs_v[0] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (rd_cnt[0] - rb >= 3) begin
            got = 1'b1;
            break;
         end
      end
      check("rst-refill 3 acks seen", {31'd0, got}, 32'd1);
      cs_v[0] = 1'b0;
      rst = 1'b1;
      #1;
      check("rst-refill rdata",     rdata_v[0], 32'h0);
      check("rst-refill mem_req",   {31'd0, mem_req_v[0]}, 32'd0);
      check("rst-refill mem_we",    {31'd0, mem_we_v[0]}, 32'd0);
      check("rst-refill mem_addr",  mem_addr_v[0], 32'h0);
      check("rst-refill mem_wdata", mem_wdata_v[0], 32'h0);
      check("rst-refill stall",     {31'd0, stall_v[0]}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst-refill idle mem_req", {31'd0, mem_req_v[0]}, 32'd0);
      do_txn(0, 1'b0, 32'h40000C00, 32'h0, 1'b1, 32'h000000A0, 8, 0, "after-rst refill");
      do_txn(0, 1'b0, 32'h40000010, 32'h0, 1'b1, 32'h000000A4, 8, 0, "after-rst line0");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
